lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DMADDRWIDTH, default `DMADDRWIDTH, word-address width of the data memory.
REQ-002 Parameter DATAWIDTH, default 32, data word width; only 32 is supported.
REQ-003 clk  input  1  single clock for all state; the memory clka and clkb are tied to it.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_ready  output  1  controller can accept a request this cycle.
REQ-011 resp_valid  output  1  single-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned access or illegal funct3; qualified by resp_valid.
REQ-014 mem_ena, mem_wea  output  1 each  memory write-port enable and write enable.
REQ-015 mem_addra  output  DMADDRWIDTH  memory write word address.
REQ-016 mem_dia  output  32  memory write data.
REQ-017 mem_enb  output  1  memory read-port enable.
REQ-018 mem_addrb  output  DMADDRWIDTH  memory read word address.
REQ-019 mem_dob  input  32  memory read data, valid one cycle after mem_enb.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, LOAD, RMW, ACK.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready.
REQ-022 Word address SHALL be req_addr[DMADDRWIDTH+1:2]; higher address bits are ignored.
REQ-023 On acceptance the controller SHALL latch funct3, req_we, addr[1:0], word address and wdata.
REQ-024 Load accepted at T: mem_enb=1 with mem_addrb driven combinationally at T; state goes to LOAD; resp_valid=1 at T+1 with data from mem_dob; state returns to IDLE.
REQ-025 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the byte or half selected by addr[1:0] (little endian: byte 0 = bits 7:0).
REQ-026 SW accepted at T: mem_ena=mem_wea=1 at T with mem_dia=req_wdata; state goes to ACK; resp_valid at T+1.
REQ-027 SB/SH accepted at T: read the word at T, go to RMW; at T+1 write (mem_dob with the target byte/half replaced by wdata[7:0]/[15:0]), go to ACK; resp_valid at T+2.
REQ-028 Misaligned requests (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) and illegal funct3 SHALL issue no memory enable, go to ACK, and give resp_valid with resp_err=1 and resp_rdata=0 at T+1.
REQ-029 mem_ena, mem_wea and mem_enb SHALL be 0 in every cycle not named in REQ-024 to REQ-027.
REQ-030 resp_valid SHALL be high for exactly one cycle per accepted request; ACK and LOAD always return to IDLE.
REQ-031 req_valid held high while req_ready=0 SHALL be ignored, with no side effect.
REQ-032 Back-to-back throughput SHALL be: load or SW one per 2 cycles; SB/SH one per 3 cycles.

Reset
REQ-033 When rst is asserted, state SHALL go to IDLE immediately and the latched request registers SHALL clear to 0.
REQ-034 While rst is high, req_ready, resp_valid, resp_err, all memory enables and resp_rdata SHALL be 0.
REQ-035 Reset during RMW SHALL suppress the pending write, and no response SHALL be issued.

Structure
REQ-036 The funct3 encodings, DMADDRWIDTH and DATAWIDTH SHALL come from the shared RV32I.h header.
REQ-037 The state encoding SHALL be local to lsu_ctrl.
REQ-038 One combinational sub-module, lsu_align, SHALL perform load extraction/extension and store byte-merge.

Verification
REQ-039 Scenario: preload word 0x8899AABB at byte address 0x10; LB at 0x11 -> resp_rdata 0xFFFFFFAA at T+1; LBU at 0x13 -> 0x00000088.
REQ-040 Scenario: SB 0x5A to 0x12 over 0x8899AABB -> read at T, write 0x885AAABB at T+1, resp_valid at T+2; a following LW returns 0x885AAABB.
REQ-041 Scenario: SW 0xDEADBEEF to 0x20 -> mem_ena=mem_wea=1, mem_addra=8 at T, resp_valid at T+1; LH at 0x22 -> 0xFFFFDEAD.
REQ-042 Scenario: LW at 0x21 and SH at 0x23 -> resp_err=1 at T+1, no memory enable, memory unchanged.
REQ-043 Scenario: rst asserted in the RMW cycle of an SB -> no write, no resp_valid, req_ready=1 in the first cycle after release.
REQ-044 Scenario: req_valid held high for 10 mixed requests -> exactly one resp_valid per acceptance, at the latencies of REQ-024 to REQ-027.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller.
//   DmAddrWidth / DataWidth : default data-memory word-address width and data width
//   F3*                     : RV32I load/store funct3 encodings
//   acc_e / lsu_classify    : decode of an incoming request into the action it needs
package lsu_ctrl_pkg;

    localparam int unsigned DmAddrWidth = 10;
    localparam int unsigned DataWidth   = 32;

    localparam logic [2:0] F3Byte  = 3'b000;  // LB / SB
    localparam logic [2:0] F3Half  = 3'b001;  // LH / SH
    localparam logic [2:0] F3Word  = 3'b010;  // LW / SW
    localparam logic [2:0] F3ByteU = 3'b100;  // LBU
    localparam logic [2:0] F3HalfU = 3'b101;  // LHU

    typedef enum logic [1:0] {
        AccLoad,  // single read, data returned next cycle
        AccSw,    // full-word write, no read needed
        AccRmw,   // sub-word store: read, merge, write
        AccErr    // misaligned or illegal funct3, no memory traffic
    } acc_e;

    function automatic acc_e lsu_classify(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
        acc_e acc;
        acc = AccErr;
        if (we) begin
            case (f3)
                F3Byte:  acc = AccRmw;
                F3Half:  acc = off[0] ? AccErr : AccRmw;
                F3Word:  acc = (off == 2'b00) ? AccSw : AccErr;
                default: acc = AccErr;
            endcase
        end else begin
            case (f3)
                F3Byte, F3ByteU: acc = AccLoad;
                F3Half, F3HalfU: acc = off[0] ? AccErr : AccLoad;
                F3Word:          acc = (off == 2'b00) ? AccLoad : AccErr;
                default:         acc = AccErr;
            endcase
        end
        return acc;
    endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// lsu_align: combinational data path of the LSU.
//   funct3     : latched access type
//   off        : latched byte offset addr[1:0]
//   rdata      : word read from memory
//   wdata      : right-aligned store data
//   load_data  : selected byte/half/word, sign- or zero-extended
//   merge_data : rdata with the target byte/half replaced by wdata (SB/SH)
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        // Little endian: byte 0 lives in bits 7:0
        sel_byte = rdata[{off, 3'b000} +: 8];
        sel_half = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3Byte:  load_data = {{24{sel_byte[7]}}, sel_byte};
            F3ByteU: load_data = {24'h0, sel_byte};
            F3Half:  load_data = {{16{sel_half[15]}}, sel_half};
            F3HalfU: load_data = {16'h0, sel_half};
            default: load_data = rdata;
        endcase

        merge_data = rdata;
        case (funct3)
            F3Byte:  merge_data[{off, 3'b000} +: 8] = wdata[7:0];
            F3Half:  merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the core and a dual-port data memory.
//   clk, rst                   : clock, asynchronous active-high reset
//   req_valid/we/funct3/addr/wdata, req_ready : request handshake from the core
//   resp_valid/rdata/err       : one-cycle completion pulse with load data or error
//   mem_ena/wea/addra/dia      : memory write port (port A)
//   mem_enb/addrb, mem_dob     : memory read port (port B), data one cycle after enable
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned DMADDRWIDTH = DmAddrWidth,
    parameter int unsigned DATAWIDTH   = DataWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [DATAWIDTH-1:0]   req_wdata,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic [DATAWIDTH-1:0]   resp_rdata,
    output logic                   resp_err,
    output logic                   mem_ena,
    output logic                   mem_wea,
    output logic [DMADDRWIDTH-1:0] mem_addra,
    output logic [DATAWIDTH-1:0]   mem_dia,
    output logic                   mem_enb,
    output logic [DMADDRWIDTH-1:0] mem_addrb,
    input  logic [DATAWIDTH-1:0]   mem_dob
);

    typedef enum logic [1:0] {StIdle, StLoad, StRmw, StAck} state_e;

    state_e                 state_q;
    logic [2:0]             f3_q;
    logic                   we_q;
    logic [1:0]             off_q;
    logic [DMADDRWIDTH-1:0] waddr_q;
    logic [DATAWIDTH-1:0]   wdata_q;
    logic                   err_q;

    logic [DMADDRWIDTH-1:0] req_word;
    acc_e                   req_acc;
    logic [31:0]            load_data;
    logic [31:0]            merge_data;

    // Bits above the memory's word address are deliberately ignored
    logic unused_bits;
    assign unused_bits = ^{req_addr[31:DMADDRWIDTH+2], we_q};

    assign req_word = req_addr[DMADDRWIDTH+1:2];
    assign req_acc  = lsu_classify(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3     (f3_q),
        .off        (off_q),
        .rdata      (mem_dob),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            f3_q    <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        f3_q    <= req_funct3;
                        we_q    <= req_we;
                        off_q   <= req_addr[1:0];
                        waddr_q <= req_word;
                        wdata_q <= req_wdata;
                        err_q   <= (req_acc == AccErr);
                        case (req_acc)
                            AccLoad: state_q <= StLoad;
                            AccRmw:  state_q <= StRmw;
                            default: state_q <= StAck;
                        endcase
                    end
                end
                StRmw:   state_q <= StAck;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory enables for the accepting cycle are combinational on the request so a
    // load or SW issues in the same cycle it is accepted; everything is gated by rst
    // so a reset mid-RMW cannot leak the write.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_ena    = 1'b0;
        mem_wea    = 1'b0;
        mem_enb    = 1'b0;
        mem_addra  = req_word;
        mem_addrb  = req_word;
        mem_dia    = req_wdata;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        case (req_acc)
                            AccLoad, AccRmw: mem_enb = 1'b1;
                            AccSw: begin
                                mem_ena = 1'b1;
                                mem_wea = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StLoad: begin
                    resp_valid = 1'b1;
                    resp_rdata = load_data;
                end
                StRmw: begin
                    mem_ena   = 1'b1;
                    mem_wea   = 1'b1;
                    mem_addra = waddr_q;
                    mem_dia   = merge_data;
                end
                StAck: begin
                    resp_valid = 1'b1;
                    resp_err   = err_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_ena;
    logic          mem_wea;
    logic [AW-1:0] mem_addra;
    logic [31:0]   mem_dia;
    logic          mem_enb;
    logic [AW-1:0] mem_addrb;
    logic [31:0]   mem_dob;

    lsu_ctrl #(.DMADDRWIDTH(AW), .DATAWIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ena    (mem_ena),
        .mem_wea    (mem_wea),
        .mem_addra  (mem_addra),
        .mem_dia    (mem_dia),
        .mem_enb    (mem_enb),
        .mem_addrb  (mem_addrb),
        .mem_dob    (mem_dob)
    );

    always #5 clk = ~clk;

    // Dual-port synchronous RAM the controller drives
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ena && mem_wea) ram[mem_addra] <= mem_dia;
        if (mem_enb) mem_dob <= ram[mem_addrb];
    end

    // Reference model: byte-addressed memory
    logic [7:0] bmem [0:(4<<AW)-1];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sbq[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        ram[w] = v;
        for (int i = 0; i < 4; i++) bmem[4*w+i] = v[8*i +: 8];
    endtask

    // Spec-level behaviour of one request; updates the model for stores.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output logic [2:0] ens);
        int a, sz;
        logic legal;
        logic [31:0] ones;
        a  = int'(addr[AW+1:0]);
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        rd = 32'h0;
        if (!legal || (a % sz) != 0) begin
            err = 1'b1; lat = 1; ens = 3'b000;
        end else if (!we) begin
            err = 1'b0; lat = 1; ens = 3'b001;
            for (int i = 0; i < sz; i++) rd = rd | (32'(bmem[a+i]) << (8*i));
            if (!f3[2] && sz < 4 && bmem[a+sz-1][7]) begin
                ones = '1;
                rd = rd | (ones << (8*sz));
            end
        end else begin
            err = 1'b0;
            for (int i = 0; i < sz; i++) bmem[a+i] = wd[8*i +: 8];
            lat = (sz == 4) ? 1 : 2;
            ens = (sz == 4) ? 3'b110 : 3'b001;
        end
    endtask

    // Called at posedge+1; keeps req_valid high and scrambles fields while not ready.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        logic done;
        logic [31:0] rd;
        logic err;
        int lat;
        logic [2:0] ens;
        exp_t e;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            req_valid = 1'b1;
            if (req_ready) begin
                req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
            end else begin
                req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                model(we, f3, addr, wd, rd, err, lat, ens);
                chk("accept_enables", {29'h0, mem_ena, mem_wea, mem_enb}, {29'h0, ens});
                if (ens == 3'b110) begin
                    chk("sw_addra", 32'(mem_addra), 32'(addr[AW+1:2]));
                    chk("sw_dia", mem_dia, wd);
                end else if (ens == 3'b001) begin
                    chk("rd_addrb", 32'(mem_addrb), 32'(addr[AW+1:2]));
                end
                e.rdata = rd; e.err = err; e.due = cyc + lat;
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(done), 32'd1);
    endtask

    // Monitor: every response must match the oldest expectation at its due cycle
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_cycle", cyc, e.due);
            end
        end
    end

    task automatic rand_req();
        logic we;
        logic [2:0] f3;
        logic [31:0] addr;
        we = 1'($urandom);
        if ($urandom_range(0, 9) < 8) begin
            f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            if (f3 == 3'd3) f3 = 3'd4;
        end else begin
            f3 = 3'($urandom);
        end
        addr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << (AW + 2));
        issue(we, f3, addr, $urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [31:0] w;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < (1 << AW); i++) preload(i, $urandom);
        preload(4, 32'h8899AABB);

        // Outputs held quiet under reset, even with a request present
        req_valid = 1'b1; req_addr = 32'h10;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_enables", {29'h0, mem_ena, mem_wea, mem_enb}, 32'd0);
        chk("rst_rdata_err", {resp_rdata[30:0], resp_err}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Directed scenarios, req_valid held across them
        issue(1'b0, 3'b000, 32'h11, 32'h0);          // LB  -> FFFFFFAA
        issue(1'b0, 3'b100, 32'h13, 32'h0);          // LBU -> 00000088
        issue(1'b1, 3'b000, 32'h12, 32'h0000005A);   // SB  -> 885AAABB
        issue(1'b0, 3'b010, 32'h10, 32'h0);          // LW
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);   // SW word 8
        issue(1'b0, 3'b001, 32'h22, 32'h0);          // LH  -> FFFFDEAD
        issue(1'b0, 3'b010, 32'h21, 32'h0);          // misaligned LW
        issue(1'b1, 3'b001, 32'h23, 32'h00001234);   // misaligned SH
        issue(1'b0, 3'b011, 32'h20, 32'h0);          // illegal funct3
        issue(1'b0, 3'b010, 32'h20, 32'h0);          // memory unchanged
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sc_sb_word", ram[4], 32'h885AAABB);
        chk("sc_sw_word", ram[8], 32'hDEADBEEF);

        // Randomized traffic with occasional bubbles
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                req_valid = 1'b0;
                @(posedge clk); #1;
            end
            rand_req();
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the RMW cycle of an SB: write and response must vanish
        w = ram[12];
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h31; req_wdata = 32'h000000C3;
        @(negedge clk);
        chk("rmw_rst_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst_no_write", {30'h0, mem_ena, mem_wea}, 32'd0);
        chk("rmw_rst_no_resp", 32'(resp_valid), 32'd0);
        chk("rmw_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmw_rst_ready_after", 32'(req_ready), 32'd1);
        chk("rmw_rst_mem", ram[12], w);
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) rand_req();
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        chk("sb_pending", sbq.size(), 32'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            for (int b = 0; b < 4; b++) if (ram[i][8*b +: 8] !== bmem[4*i+b]) bad++;
        end
        chk("mem_final_bad_bytes", bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
